// File: rtl/gray_to_binary_sched.sv
// gray_to_binary_sched
//   Round-robin scheduler that shares one Gray-to-binary converter among
//   NUM_REQ requesters. Results return tagged with the requester index.
//   Build option: define GRAY_PARALLEL_EN for a single-cycle combinational
//   converter; by default the converter resolves one bit per cycle, MSB first.
module gray_to_binary_sched #(
   parameter int SIZE    = 4,
   parameter int NUM_REQ = 2,
   parameter int IDW     = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*SIZE-1:0] req_gray,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SIZE-1:0]         out_bin,
   output logic [IDW-1:0]          out_id,
   output logic                    busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   r_id;
   logic [SIZE-1:0]  r_gray;
   logic [SIZE-1:0]  r_bin;
   logic             r_out_valid;
   logic             r_busy;

   logic [NUM_REQ-1:0] w_req_rot;
   logic [NUM_REQ-1:0] w_grant_oh;
   logic               w_grant_any;
   logic [IDW-1:0]     w_grant_id;
   logic [IDW-1:0]     w_rr_next;
   logic [SIZE-1:0]    w_sel_gray;
   logic               w_conv_last;

   // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      w_req_rot   = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);
      w_grant_any = |w_req_rot;
      w_grant_id  = r_rr_ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_req_rot[i]) begin
            w_grant_id = IDW'((int'(r_rr_ptr) + i) % NUM_REQ);
         end
      end
      w_grant_oh = NUM_REQ'(1) << w_grant_id;
      w_rr_next  = (w_grant_id == IDW'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
      w_sel_gray = SIZE'(req_gray >> (int'(w_grant_id) * SIZE));
   end

`ifdef GRAY_PARALLEL_EN
   logic [SIZE-1:0] w_par_bin;

   // Whole word at once: bin[i] is the XOR of gray[SIZE-1:i].
   always_comb begin
      w_par_bin = '0;
      for (int i = 0; i < SIZE; i++) begin
         w_par_bin[i] = ^(r_gray >> i);
      end
   end

   assign w_conv_last = 1'b1;
`else
   localparam int KW = (SIZE > 1) ? $clog2(SIZE) : 1;

   logic [KW-1:0] r_k;
   logic          w_bit;

   // The gray word shifts left so its current bit sits at the MSB; r_bin[0]
   // holds the previously resolved (more significant) binary bit.
   assign w_conv_last = (r_k == '0);
   assign w_bit       = r_bin[0] ^ r_gray[SIZE-1];
`endif

   // Next-state and grant decode; grants only leave the block from IDLE.
   always_comb begin
      w_next_state = r_state;
      req_ready    = '0;
      case (r_state)
         S_IDLE: begin
            if (w_grant_any) begin
               req_ready    = w_grant_oh;
               w_next_state = S_CONVERT;
            end
         end
         S_CONVERT: begin
            if (w_conv_last) w_next_state = S_DONE;
         end
         S_DONE: begin
            // out_valid is always high here, so out_ready alone completes the handshake.
            if (out_ready) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
      if (rst) req_ready = '0;
   end

   // State register with busy registered from the next-state decode.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != S_IDLE);
      end
   end

   // Datapath: capture on grant, convert, present and hold the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr    <= '0;
         r_id        <= '0;
         r_gray      <= '0;
         r_bin       <= '0;
         r_out_valid <= 1'b0;
`ifndef GRAY_PARALLEL_EN
         r_k         <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_any) begin
                  r_gray   <= w_sel_gray;
                  r_id     <= w_grant_id;
                  r_rr_ptr <= w_rr_next;
`ifndef GRAY_PARALLEL_EN
                  r_bin    <= '0;
                  r_k      <= KW'(SIZE - 1);
`endif
               end
            end
            S_CONVERT: begin
`ifdef GRAY_PARALLEL_EN
               r_bin  <= w_par_bin;
`else
               r_bin  <= {r_bin[SIZE-2:0], w_bit};
               r_gray <= r_gray << 1;
               r_k    <= r_k - 1'b1;
`endif
               if (w_conv_last) r_out_valid <= 1'b1;
            end
            S_DONE: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_bin   = r_bin;
   assign out_id    = r_id;
   assign busy      = r_busy;

endmodule
